inv_mix_column_sequencer: RTL
=============================

// Module: inv_mix_column_sequencer
// PURPOSE
//  Sequences one AES InvMixColumns column (4 bytes) through the shared GF(2^8) constant-multiply
//  ROMs (x09, x0B, x0D, x0E); XOR-accumulates the products into the 32-bit result column.
//  Sits between the decrypt round datapath (valid/ready column stream) and the four ROMs.
//  Issues one byte address per cycle to all four ROMs; accumulation is pipelined behind the issue.
// PARAMETERS
//  ROM_LATENCY  1   cycles from Read_Enable/Address sampled to Read_Data valid (legal: 1..2)
//  CNT_WIDTH    16  width of Column_Count (used only with INV_MIX_CNT_EN)
// PORTS
//  CLK              in   1   clock, rising edge
//  RST_N            in   1   asynchronous active-low reset
//  In_Valid         in   1   In_Column valid
//  In_Ready         out  1   sequencer can accept a column
//  In_Column        in   32  a0=[31:24], a1=[23:16], a2=[15:8], a3=[7:0]
//  Out_Valid        out  1   Out_Column valid, held until accepted
//  Out_Ready        in   1   consumer accepts Out_Column
//  Out_Column       out  32  b0=[31:24] .. b3=[7:0]
//  Rom_Read_Enable  out  1   common enable to x09/x0B/x0D/x0E ROMs
//  Rom_Read_Address out  8   common address (byte a_i under issue)
//  Mul9_Data,MulB_Data,MulD_Data,MulE_Data  in  8 each  ROM read data; 8'h00 when not enabled
//  Column_Count     out  CNT_WIDTH  completed columns (INV_MIX_CNT_EN only)
// BEHAVIOUR
//  - b_r = E*a_r ^ B*a_(r+1) ^ D*a_(r+2) ^ 9*a_(r+3), indices mod 4.
//  - Returned byte i: acc[i]^=E, acc[i-1]^=B, acc[i-2]^=D, acc[i-3]^=9 (mod 4), all same edge.
//  - FSM: IDLE -> ISSUE (4 cycles, idx 0..3) -> DRAIN (ROM_LATENCY cycles) -> DONE -> IDLE.
//  - IDLE: In_Ready=1. Handshake In_Valid&In_Ready captures In_Column, clears acc, -> ISSUE.
//  - ISSUE: Rom_Read_Enable=1, Rom_Read_Address=a_idx; idx wraps 3->0 on exit.
//  - Return tracking: ROM_LATENCY-deep shift reg of {valid,idx}; accumulate only when valid.
//  - DRAIN: enable low; last product accumulates on final DRAIN edge -> DONE.
//  - Latency: Out_Valid rises ROM_LATENCY+4 edges after accepting edge (5 at default).
//  - DONE: Out_Valid=1, Out_Column=acc stable while Out_Ready=0 (no change, no re-issue).
//  - Out_Valid&Out_Ready -> IDLE; In_Ready rises next cycle (no same-cycle accept/complete).
//  - In_Ready, Out_Valid, Rom_Read_Enable registered; Out_Column driven from acc register.
//  - In_Valid outside IDLE ignored; In_Column sampled only on handshake edge.
//  - Rom_Read_Enable=0 outside ISSUE; Rom_Read_Address=8'h00 when enable low.
//  - Reset (any state, async): FSM=IDLE, In_Ready=0 (rises first edge after release),
//    Out_Valid=0, Out_Column=0, Rom_Read_Enable=0, Rom_Read_Address=0, acc/pipe=0,
//    Column_Count=0. In-flight column discarded; ROM data in flight ignored (pipe valid cleared).
// CONFIGURATION
//  INV_MIX_CNT_EN defined: Column_Count port present; +1 on each Out_Valid&Out_Ready,
//    wraps all-ones -> 0.
//  INV_MIX_CNT_EN undefined: Column_Count port and counter absent; behaviour otherwise identical.
// TESTING
//  T1 reset mid-ISSUE (RST_N low 1 cycle) -> all outputs 0, then IDLE, In_Ready=1, no Out_Valid.
//  T2 In_Column=32'h8E4DA1BC -> Out_Column=32'hDB135345, Out_Valid 5 edges after accept.
//  T3 In_Column=32'h9FDC589D -> 32'hF20A225C; Rom_Read_Address seq 9F,DC,58,9D.
//  T4 32'h01010101 -> 32'h01010101; 32'hC6C6C6C6 -> 32'hC6C6C6C6; 32'h0 -> 32'h0.
//  T5 Out_Ready=0 10 cycles in DONE -> Out_Column/Out_Valid stable, In_Ready=0, enable=0;
//     In_Valid pulses ignored.
//  T6 INV_MIX_CNT_EN, 3 back-to-back columns -> Column_Count 0->3; bench ROM_LATENCY=2 -> latency 6.

Source files
------------

// File: rtl/inv_mix_column_sequencer_if.sv
// Column stream (in/out) and shared GF(2^8) constant-multiply ROM port bundle
// for the InvMixColumns sequencer. slave = sequencer side, master = environment.
interface inv_mix_column_sequencer_if;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_Column;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Column;
    logic        Rom_Read_Enable;
    logic [7:0]  Rom_Read_Address;
    logic [7:0]  Mul9_Data;
    logic [7:0]  MulB_Data;
    logic [7:0]  MulD_Data;
    logic [7:0]  MulE_Data;

    modport slave (
        input  In_Valid, In_Column, Out_Ready,
        input  Mul9_Data, MulB_Data, MulD_Data, MulE_Data,
        output In_Ready, Out_Valid, Out_Column, Rom_Read_Enable, Rom_Read_Address
    );

    modport master (
        output In_Valid, In_Column, Out_Ready,
        output Mul9_Data, MulB_Data, MulD_Data, MulE_Data,
        input  In_Ready, Out_Valid, Out_Column, Rom_Read_Enable, Rom_Read_Address
    );
endinterface

// File: rtl/inv_mix_column_sequencer.sv
// Sequences one AES InvMixColumns column through shared x09/x0B/x0D/x0E ROMs and
// XOR-accumulates the products. Optional INV_MIX_CNT_EN adds a Column_Count port.
module inv_mix_column_sequencer #(
    parameter int ROM_LATENCY = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic CLK,
    input  logic RST_N,
    inv_mix_column_sequencer_if.slave bus
`ifdef INV_MIX_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] Column_Count
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                      state;
    logic [0:3][7:0]             col_q;      // [0] = a0 = In_Column[31:24]
    logic [0:3][7:0]             acc;
    logic [0:3][7:0]             acc_nxt;
    logic [1:0]                  idx;
    logic [1:0]                  drain_cnt;
    logic [1:0]                  ret_idx;
    logic [ROM_LATENCY-1:0]      vld_pipe;
    logic [ROM_LATENCY-1:0][1:0] idx_pipe;
    logic                        in_rdy;
    logic                        out_vld;
    logic                        ren;
    logic [7:0]                  raddr;

    assign bus.In_Ready         = in_rdy;
    assign bus.Out_Valid        = out_vld;
    assign bus.Out_Column       = acc;
    assign bus.Rom_Read_Enable  = ren;
    assign bus.Rom_Read_Address = raddr;

    assign ret_idx = idx_pipe[ROM_LATENCY-1];

    // Returning byte a_i feeds b_i (x0E), b_(i-1) (x0B), b_(i-2) (x0D), b_(i-3) (x09)
    always_comb begin
        acc_nxt = acc;
        if (vld_pipe[ROM_LATENCY-1]) begin
            acc_nxt[ret_idx]         = acc_nxt[ret_idx]         ^ bus.MulE_Data;
            acc_nxt[ret_idx - 2'd1]  = acc_nxt[ret_idx - 2'd1]  ^ bus.MulB_Data;
            acc_nxt[ret_idx - 2'd2]  = acc_nxt[ret_idx - 2'd2]  ^ bus.MulD_Data;
            acc_nxt[ret_idx - 2'd3]  = acc_nxt[ret_idx - 2'd3]  ^ bus.Mul9_Data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            col_q     <= '0;
            acc       <= '0;
            idx       <= '0;
            drain_cnt <= '0;
            vld_pipe  <= '0;
            idx_pipe  <= '0;
            in_rdy    <= 1'b0;
            out_vld   <= 1'b0;
            ren       <= 1'b0;
            raddr     <= 8'h00;
        end else begin
            // Tracks which byte each outstanding ROM read belongs to
            vld_pipe[0] <= ren;
            idx_pipe[0] <= idx;
            for (int k = 1; k < ROM_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
            acc <= acc_nxt;

            case (state)
                IDLE: begin
                    if (in_rdy && bus.In_Valid) begin
                        col_q  <= bus.In_Column;
                        acc    <= '0;
                        in_rdy <= 1'b0;
                        ren    <= 1'b1;
                        raddr  <= bus.In_Column[31:24];
                        idx    <= 2'd0;
                        state  <= ISSUE;
                    end else begin
                        in_rdy <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (idx == 2'd3) begin
                        ren       <= 1'b0;
                        raddr     <= 8'h00;
                        idx       <= 2'd0;
                        drain_cnt <= 2'd0;
                        state     <= DRAIN;
                    end else begin
                        idx   <= idx + 2'd1;
                        raddr <= col_q[idx + 2'd1];
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(ROM_LATENCY - 1)) begin
                        out_vld <= 1'b1;
                        state   <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.Out_Ready) begin
                        out_vld <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef INV_MIX_CNT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            Column_Count <= '0;
        else if (out_vld && bus.Out_Ready)
            Column_Count <= Column_Count + 1'b1;
    end
`endif

endmodule
